// File: rtl/alu8_pkg.sv
// Shared types and constants for the 8-bit ALU command front-end.
// Holds the ALU opcode map, the controller FSM state type, the default FIFO
// depth and the packed command payload {a, b, op}.
// ALU8_CMD_ERR_EN adds the ERR state and marks opcodes 4'b1100..4'b1111 illegal.
package alu8_pkg;

    localparam int unsigned DATA_W             = 8;
    localparam int unsigned PROD_W             = 16;
    localparam int unsigned OP_W               = 4;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    localparam logic [OP_W-1:0] OP_INV  = 4'b0000;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0001;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0010;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLA  = 4'b0110;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b1010;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1011;
    localparam logic [OP_W-1:0] OP_ZERO = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
`ifdef ALU8_CMD_ERR_EN
        ST_ERR  = 2'd3,
`endif
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu8_cmd_t;

    // Opcodes 4'b11xx have no ALU operation behind them (ZERO excepted only
    // when the error path is disabled).
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/alu8_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push_i      write wdata_i (ignored while not ready)
//   wdata_i     command to enqueue
//   pop_i       drop the head entry (ignored while empty)
//   head_c      current head entry (combinational read)
//   empty_c     no entries (combinational from count)
//   ready_o     registered !full
//   count_o     registered occupancy, 0..DEPTH
module alu8_cmd_fifo
    import alu8_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  alu8_cmd_t     wdata_i,
    input  logic          pop_i,
    output alu8_cmd_t     head_c,
    output logic          empty_c,
    output logic          ready_o,
    output logic [CW-1:0] count_o
);

    alu8_cmd_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ready_q;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign push_ok_c = push_i && ready_q;
    assign pop_ok_c  = pop_i && (count_q != '0);

    // Simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Storage needs no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign ready_o = ready_q;
    assign count_o = count_q;

endmodule

// File: rtl/alu8_cmd_ctrl.sv
// Command front-end and result capture stage for the 8-bit ALU.
// Buffers {a, b, op} commands in a FIFO, drives the ALU inputs from registers,
// waits ALU_WAIT cycles, then captures the ALU outputs into a response
// register held under a valid/ready handshake.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a, alu_b, alu_op           registered ALU inputs
//   alu_result, alu_product,
//   alu_of, alu_zero, alu_slt      ALU outputs
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_product,
//   rsp_of, rsp_zero, rsp_slt      captured ALU outputs
//   rsp_err                        illegal opcode flag
//   fifo_level                     FIFO occupancy
// Build option: ALU8_CMD_ERR_EN rejects opcodes 4'b1100..4'b1111 through an
// ERR state; without it rsp_err is tied 0 and every opcode issues.
module alu8_cmd_ctrl
    import alu8_pkg::*;
#(
    parameter  int unsigned ALU_WAIT   = 1,
    parameter  int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [PROD_W-1:0] alu_product,
    input  logic              alu_of,
    input  logic              alu_zero,
    input  logic              alu_slt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [PROD_W-1:0] rsp_product,
    output logic              rsp_of,
    output logic              rsp_zero,
    output logic              rsp_slt,
    output logic              rsp_err,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int unsigned CNT_W = 3;

    state_e            state_q, state_d;
    state_e            issue_state_c;
    alu8_cmd_t         wr_cmd_c;
    alu8_cmd_t         head_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              head_illegal_c;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [PROD_W-1:0] rsp_product_q, rsp_product_d;
    logic              rsp_of_q, rsp_of_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_slt_q, rsp_slt_d;
`ifdef ALU8_CMD_ERR_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    assign push_c   = cmd_valid && cmd_ready;
    assign wr_cmd_c = '{a: cmd_a, b: cmd_b, op: cmd_op};

    alu8_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (wr_cmd_c),
        .pop_i   (pop_c),
        .head_c  (head_c),
        .empty_c (empty_c),
        .ready_o (cmd_ready),
        .count_o (fifo_level)
    );

    // Where a pop of the head command leads.
`ifdef ALU8_CMD_ERR_EN
    assign head_illegal_c = op_is_illegal(head_c.op);
    assign issue_state_c  = head_illegal_c ? ST_ERR : ST_WAIT;
`else
    assign head_illegal_c = 1'b0;
    assign issue_state_c  = ST_WAIT;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= OP_ZERO;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_product_q <= '0;
            rsp_of_q      <= 1'b0;
            rsp_zero_q    <= 1'b0;
            rsp_slt_q     <= 1'b0;
`ifdef ALU8_CMD_ERR_EN
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_product_q <= rsp_product_d;
            rsp_of_q      <= rsp_of_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_slt_q     <= rsp_slt_d;
`ifdef ALU8_CMD_ERR_EN
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d = issue_state_c;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = empty_c ? ST_IDLE : issue_state_c;
                end
            end
`ifdef ALU8_CMD_ERR_EN
            ST_ERR: begin
                state_d = ST_RESP;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: pop/issue, settle counter, response capture.
    always_comb begin
        pop_c         = 1'b0;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_product_d = rsp_product_q;
        rsp_of_d      = rsp_of_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_slt_d     = rsp_slt_q;
`ifdef ALU8_CMD_ERR_EN
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                pop_c = !empty_c;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = alu_result;
                    rsp_product_d = alu_product;
                    rsp_of_d      = alu_of;
                    rsp_zero_d    = alu_zero;
                    rsp_slt_d     = alu_slt;
`ifdef ALU8_CMD_ERR_EN
                    rsp_err_d     = 1'b0;
`endif
                end
            end
            ST_RESP: begin
                // Data fields keep their last value; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    pop_c       = !empty_c;
                end
            end
`ifdef ALU8_CMD_ERR_EN
            ST_ERR: begin
                rsp_valid_d   = 1'b1;
                rsp_result_d  = '0;
                rsp_product_d = '0;
                rsp_of_d      = 1'b0;
                rsp_zero_d    = 1'b0;
                rsp_slt_d     = 1'b0;
                rsp_err_d     = 1'b1;
            end
`endif
            default: begin
                pop_c = 1'b0;
            end
        endcase

        // Illegal commands leave the ALU inputs untouched.
        if (pop_c && !head_illegal_c) begin
            alu_a_d  = head_c.a;
            alu_b_d  = head_c.b;
            alu_op_d = head_c.op;
            cnt_d    = CNT_W'(ALU_WAIT);
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_product = rsp_product_q;
    assign rsp_of      = rsp_of_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_slt     = rsp_slt_q;
`ifdef ALU8_CMD_ERR_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu8_cmd_ctrl.sv
// Self-checking bench for alu8_cmd_ctrl with a behavioural ALU stub and a
// queue-based response model.
`timescale 1ns/1ps
module tb_alu8_cmd_ctrl;
    import alu8_pkg::*;

    typedef struct packed {
        logic [7:0]  result;
        logic [15:0] product;
        logic        of_f;
        logic        zero_f;
        logic        slt_f;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic [15:0] alu_product;
    logic        alu_of, alu_zero, alu_slt;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_result;
    logic [15:0] rsp_product;
    logic        rsp_of, rsp_zero, rsp_slt, rsp_err;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu8_cmd_ctrl #(.ALU_WAIT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_product(alu_product),
        .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_product(rsp_product),
        .rsp_of(rsp_of), .rsp_zero(rsp_zero), .rsp_slt(rsp_slt),
        .rsp_err(rsp_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 8-bit ALU sitting downstream of the DUT.
    function automatic rsp_t alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        rsp_t        r;
        logic [15:0] w;
        logic [2:0]  sh;
        r  = '0;
        sh = b[2:0];
        w  = {a, a};
        case (op)
            OP_INV: r.result = ~a;
            OP_AND: r.result = a & b;
            OP_OR:  r.result = a | b;
            OP_SRL: r.result = a >> sh;
            OP_SLL, OP_SLA: r.result = a << sh;
            OP_SRA: r.result = $signed(a) >>> sh;
            OP_ROR: begin w = w >> sh; r.result = w[7:0]; end
            OP_ROL: begin w = w << sh; r.result = w[15:8]; end
            OP_ADD: begin
                r.result = a + b;
                r.of_f   = (a[7] == b[7]) && (r.result[7] != a[7]);
            end
            OP_SUB: begin
                r.result = a - b;
                r.of_f   = (a[7] != b[7]) && (r.result[7] != a[7]);
                r.slt_f  = ($signed(a) < $signed(b));
            end
            OP_MUL: r.product = {{8{a[7]}}, a} * {{8{b[7]}}, b};
            default: r = '0;
        endcase
        if (op < 4'd12) r.zero_f = (r.result == 8'h00);
        return r;
    endfunction

    // Response the controller must deliver for a command.
    function automatic rsp_t expect_rsp(input alu8_cmd_t c);
        rsp_t r;
        r = alu_fn(c.a, c.b, c.op);
`ifdef ALU8_CMD_ERR_EN
        if (c.op >= 4'd12) begin
            r     = '0;
            r.err = 1'b1;
        end
`endif
        return r;
    endfunction

    rsp_t alu_out;
    rsp_t got;
    always_comb alu_out = alu_fn(alu_a, alu_b, alu_op);
    assign alu_result  = alu_out.result;
    assign alu_product = alu_out.product;
    assign alu_of      = alu_out.of_f;
    assign alu_zero    = alu_out.zero_f;
    assign alu_slt     = alu_out.slt_f;
    assign got = {rsp_result, rsp_product, rsp_of, rsp_zero, rsp_slt, rsp_err};

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic alu8_cmd_t rand_cmd(input bit legal_only);
        alu8_cmd_t c;
        c.a  = 8'($urandom_range(0, 255));
        c.b  = 8'($urandom_range(0, 255));
        c.op = legal_only ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
        return c;
    endfunction

    task automatic test_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        total++; if ({alu_a, alu_b, alu_op} !== {8'h00, 8'h00, 4'hF}) begin
            bad++; $display("FAIL reset_alu got %h/%h/%h want 00/00/f", alu_a, alu_b, alu_op); end
        total++; if (got !== rsp_t'(0)) begin bad++; $display("FAIL reset_rsp got %h want 0", got); end
    endtask

    task automatic test_directed();
        alu8_cmd_t   dc  [3];
        logic [7:0]  dr  [3];
        logic [15:0] dp  [3];
        rsp_t        exp;
        dc[0] = '{a: 8'h05, b: 8'h03, op: OP_ADD}; dr[0] = 8'h08; dp[0] = 16'h0000;
        dc[1] = '{a: 8'h03, b: 8'h05, op: OP_SUB}; dr[1] = 8'hFE; dp[1] = 16'h0000;
        dc[2] = '{a: 8'hFD, b: 8'h04, op: OP_MUL}; dr[2] = 8'h00; dp[2] = 16'hFFF4;
        for (int i = 0; i < 3; i++) begin
            exp = expect_rsp(dc[i]);
            rsp_ready = 1'b0;
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_ready got %b want 1", i, cmd_ready); end
            cmd_valid = 1'b1; cmd_a = dc[i].a; cmd_b = dc[i].b; cmd_op = dc[i].op;
            @(negedge clk);                     // after push edge N
            cmd_valid = 1'b0;
            total++; if (fifo_level !== 3'd1 || rsp_valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_n1 level=%0d valid=%b want 1/0", i, fifo_level, rsp_valid); end
            @(negedge clk);                     // after pop edge N+1
            total++; if ({alu_a, alu_b, alu_op, fifo_level, rsp_valid} !== {dc[i].a, dc[i].b, dc[i].op, 3'd0, 1'b0}) begin
                bad++; $display("FAIL dir%0d_issue got %h/%h/%h lvl=%0d v=%b want %h/%h/%h lvl=0 v=0",
                                i, alu_a, alu_b, alu_op, fifo_level, rsp_valid, dc[i].a, dc[i].b, dc[i].op); end
            @(negedge clk);                     // after capture edge N+2
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got %b want 1", i, rsp_valid); end
            total++; if (got !== exp || rsp_result !== dr[i] || rsp_product !== dp[i]) begin
                bad++; $display("FAIL dir%0d_data got %h want %h (result %h product %h)", i, got, exp, dr[i], dp[i]); end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            total++; if (rsp_valid !== 1'b0 || got !== exp) begin
                bad++; $display("FAIL dir%0d_after_hs valid=%b data %h want 0 / %h", i, rsp_valid, got, exp); end
        end
    endtask

    task automatic test_backpressure();
        alu8_cmd_t q[$];
        alu8_cmd_t c;
        rsp_t      exp;
        int        acc = 0, nrsp = 0, last = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c = rand_cmd(1'b1);
            cmd_valid = 1'b1; cmd_a = c.a; cmd_b = c.b; cmd_op = c.op;
            if (cmd_ready) begin acc++; q.push_back(c); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total++; if (acc != 5) begin bad++; $display("FAIL bp_accepted got %0d want 5", acc); end
        total++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
            bad++; $display("FAIL bp_full ready=%b level=%0d want 0/4", cmd_ready, fifo_level); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && nrsp < 5; k++) begin
            if (rsp_valid) begin
                exp = (q.size() > 0) ? expect_rsp(q.pop_front()) : rsp_t'(0);
                total++; if (got !== exp) begin bad++; $display("FAIL bp_rsp%0d got %h want %h", nrsp, got, exp); end
                if (nrsp > 0) begin
                    total++; if (cyc - last != 2) begin bad++; $display("FAIL bp_spacing%0d got %0d want 2", nrsp, cyc - last); end
                end
                last = cyc;
                nrsp++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        total++; if (nrsp != 5) begin bad++; $display("FAIL bp_count got %0d want 5", nrsp); end
        total++; if (rsp_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL bp_drained valid=%b level=%0d want 0/0", rsp_valid, fifo_level); end
    endtask

    task automatic test_random();
        alu8_cmd_t q[$];
        alu8_cmd_t c;
        rsp_t      exp, prev;
        bit        hold = 1'b0;
        int        n = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold) begin
                total++; if (rsp_valid !== 1'b1 || got !== prev) begin
                    bad++; $display("FAIL rnd_hold cyc=%0d valid=%b data %h want 1 / %h", cyc, rsp_valid, got, prev); end
            end
            c = rand_cmd(1'b0);
            cmd_valid = 1'($urandom_range(0, 1)); cmd_a = c.a; cmd_b = c.b; cmd_op = c.op;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_unexpected got %h want none", got); end
                else begin
                    exp = expect_rsp(q.pop_front());
                    if (got !== exp) begin bad++; $display("FAIL rnd_rsp%0d got %h want %h", n, got, exp); end
                end
                n++;
            end
            if (cmd_valid && cmd_ready) q.push_back(c);
            hold = rsp_valid && !rsp_ready;
            prev = got;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 200 && q.size() > 0; k++) begin
            if (rsp_valid) begin
                exp = expect_rsp(q.pop_front());
                total++; if (got !== exp) begin bad++; $display("FAIL rnd_drain%0d got %h want %h", n, got, exp); end
                n++;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (q.size() != 0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rnd_leftover got %0d pending valid=%b want 0/0", q.size(), rsp_valid); end
    endtask

    task automatic test_reset_midop();
        alu8_cmd_t c;
        bit        seen = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = rand_cmd(1'b1);
            cmd_valid = 1'b1; cmd_a = c.a; cmd_b = c.b; cmd_op = c.op;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total++; if (fifo_level !== 3'd3 || rsp_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre level=%0d valid=%b want 3/1", fifo_level, rsp_valid); end
        rsp_ready = 1'b1;
        @(negedge clk);                         // handshake pops next command into WAIT
        rsp_ready = 1'b0;
        total++; if (fifo_level !== 3'd2 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_wait level=%0d valid=%b want 2/0", fifo_level, rsp_valid); end
        rst_n = 1'b0;
        #1;
        total++; if ({rsp_valid, fifo_level, alu_op, alu_a, cmd_ready} !== {1'b0, 3'd0, 4'hF, 8'h00, 1'b1}) begin
            bad++; $display("FAIL rst_async valid=%b level=%0d op=%h a=%h ready=%b want 0/0/f/00/1",
                            rsp_valid, fifo_level, alu_op, alu_a, cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        total++; if (seen || fifo_level !== 3'd0) begin
            bad++; $display("FAIL rst_no_rsp seen=%b level=%0d want 0/0", seen, fifo_level); end
    endtask

    task automatic test_illegal_op();
        alu8_cmd_t c;
        rsp_t      exp;
        logic [19:0] exp_alu;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = OP_AND;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        c = '{a: 8'h5A, b: 8'hA5, op: 4'b1100};
        exp = expect_rsp(c);
`ifdef ALU8_CMD_ERR_EN
        exp_alu = {8'h12, 8'h34, OP_AND};
`else
        exp_alu = {c.a, c.b, c.op};
`endif
        cmd_valid = 1'b1; cmd_a = c.a; cmd_b = c.b; cmd_op = c.op;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);                         // after pop
        total++; if ({alu_a, alu_b, alu_op} !== exp_alu) begin
            bad++; $display("FAIL ill_alu got %h want %h", {alu_a, alu_b, alu_op}, exp_alu); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || got !== exp) begin
            bad++; $display("FAIL ill_rsp valid=%b got %h want 1 / %h", rsp_valid, got, exp); end
        total++; if (rsp_result !== 8'h00) begin bad++; $display("FAIL ill_result got %h want 00", rsp_result); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midop();
        test_illegal_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu8_cmd_ctrl.md
# alu8_cmd_ctrl

Command front-end and result capture stage for the 8-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a 4-entry FIFO. It drives the ALU's `a`, `b` and `Op` inputs from registers, waits a fixed settle time, then captures `result`, `product`, `OF`, `zero` and `slt` into a response register held under a second valid/ready handshake. It sits directly upstream of the ALU, feeding it, and also consumes its outputs.

## Interface
Parameters:
- `ALU_WAIT`, default 1: cycles between ALU input update and result capture. Legal range 1..7.
- `FIFO_DEPTH`, default 4: command FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  FIFO can accept
- `cmd_a`, `cmd_b`  in  8  operands
- `cmd_op`  in  4  ALU opcode
- `alu_a`, `alu_b`  out  8  registered ALU operands
- `alu_op`  out  4  registered ALU opcode
- `alu_result`  in  8  ALU `result`
- `alu_product`  in  16  ALU `product`
- `alu_of`, `alu_zero`, `alu_slt`  in  1  ALU flags
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts
- `rsp_result`  out  8  captured result
- `rsp_product`  out  16  captured product
- `rsp_of`, `rsp_zero`, `rsp_slt`  out  1  captured flags
- `rsp_err`  out  1  illegal opcode; tied 0 without `ALU8_CMD_ERR_EN`
- `fifo_level`  out  3  FIFO occupancy, 0..4

## Operation
- Command push: on `cmd_valid && cmd_ready`. `cmd_ready` is `!full` and is registered from occupancy only, so a pop in the same cycle does not raise it.
- A push and a pop in the same cycle leave `fifo_level` unchanged.
- The FSM has four states: IDLE, WAIT, RESP and ERR.
- IDLE, FIFO non-empty:
  - Pop the head and load `alu_a`, `alu_b`, `alu_op`.
  - Load the wait counter with `ALU_WAIT`.
  - Go to WAIT.
- WAIT: decrement the counter. When it reaches 0:
  - Capture all ALU outputs into the `rsp_*` registers.
  - Set `rsp_valid`.
  - Go to RESP.
- RESP: hold all `rsp_*` values stable while `rsp_valid && !rsp_ready`. On the handshake:
  - If the FIFO is non-empty, pop and load the ALU registers on the same edge, then go to WAIT (back-to-back).
  - Otherwise clear `rsp_valid` and go to IDLE.
- ERR: only exists with `ALU8_CMD_ERR_EN`; see Configuration.
- `alu_*` registers hold their last value between commands.
- `rsp_*` data fields hold their last value after the handshake; only `rsp_valid` drops.
- Reset values:
  - `alu_a = alu_b = 0x00`, `alu_op = 4'b1111` (ALU set-zero).
  - All `rsp_*` = 0, `rsp_valid = 0`.
  - FIFO empty, `fifo_level = 0`, `cmd_ready = 1`, FSM in IDLE.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded. No response is produced for them.
- Capacity: `FIFO_DEPTH` buffered commands plus one executing. With `rsp_ready` low, 5 commands are accepted before `cmd_ready` drops.

## Timing
- Command accepted at edge N into an empty FIFO with the FSM in IDLE:
  - `fifo_level = 1` from N+1.
  - Pop at edge N+1; `alu_*` valid from N+2.
  - Capture at edge N+1+`ALU_WAIT`; `rsp_valid` high from that edge.
  - With default `ALU_WAIT = 1`, `rsp_valid` is high in cycle N+3.
- Sustained throughput with `rsp_ready` held high: one response per `ALU_WAIT`+1 cycles.
- `rsp_valid` never drops without a handshake, except on reset.

## Configuration
- Macro: `ALU8_CMD_ERR_EN`.
- When defined, opcodes `4'b1100`–`4'b1111` are illegal:
  - On pop, `alu_*` are not updated.
  - The FSM goes through ERR (one cycle) to RESP.
  - Response carries `rsp_err = 1` and all data/flag fields 0.
  - Latency from pop to `rsp_valid`: 1 cycle.
- When undefined:
  - All opcodes issue normally; the ALU returns zero for the unused opcodes.
  - `rsp_err` is constant 0 and there is no ERR state.

## Structure
- Package `alu8_pkg`:
  - Opcode localparams (INV, AND, OR, SRL, SLL, SRA, SLA, ROR, ROL, ADD, SUB, MUL, ZERO).
  - FSM state enum.
  - Default FIFO depth.
  - Command struct `{a, b, op}`.
- One sub-module, `alu8_cmd_fifo`: synchronous FIFO with count, full/empty, push/pop, and async active-low reset.

## Test plan
- Reset, then ADD `a=0x05`, `b=0x03`, op `4'b1001` → `rsp_valid` at N+3; `rsp_result = 0x08`, `rsp_product = 0`, `rsp_of = 0`.
- SUB `a=0x03`, `b=0x05`, op `4'b1010` → `rsp_result = 0xFE`, `rsp_slt = 1`, `rsp_of = 0`.
- MUL `a=0xFD`, `b=0x04`, op `4'b1011` → `rsp_product = 0xFFF4`, `rsp_result = 0x00`.
- Backpressure: `rsp_ready = 0`, push 6 commands →
  - Exactly 5 accepted; `cmd_ready = 0` with `fifo_level = 4`.
  - Then `rsp_ready = 1` → 5 responses in order, one per 2 cycles, data matching each command.
- Reset asserted during WAIT with 2 commands queued → immediately `rsp_valid = 0`, `fifo_level = 0`, `alu_op = 4'b1111`; no response after release.
- With `ALU8_CMD_ERR_EN`, op `4'b1100` → response 1 cycle after pop, `rsp_err = 1`, all data 0, `alu_*` unchanged; without the macro → `rsp_err = 0`, `rsp_result = 0x00`.
